// File: rtl/rvfpm_xif_pkg.sv
`default_nettype none
// ============================================================================
// Package : rvfpm_xif_pkg
// Purpose : Shared types for the rvfpm CORE-V-XIF initiator. Holds the id
//           type, the initiator FSM state encoding, and the issue/result
//           payload layouts at the default XIF widths.
// Revision: 1.0 - initial release
// ============================================================================
package rvfpm_xif_pkg;

  localparam int XIF_ID_WIDTH = 4;
  localparam int XIF_XLEN     = 32;

  typedef logic [XIF_ID_WIDTH-1:0] xif_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } initiator_state_t;

  // Issue request payload as presented on the XIF issue interface.
  typedef struct packed {
    logic [31:0]         instr;
    logic [XIF_XLEN-1:0] rs1;
    xif_id_t             id;
  } xif_issue_req_t;

  // Result payload as returned on the XIF result interface.
  typedef struct packed {
    xif_id_t             id;
    logic [XIF_XLEN-1:0] data;
  } xif_result_t;

endpackage
`default_nettype wire

// File: rtl/rvfpm_xif_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : rvfpm_xif_scoreboard
// Purpose : Per-id outstanding bits plus a running count of set bits.
//           One set port (issue) and two clear ports (commit kill, result).
//           Callers only assert a clear for an id whose bit is set, and never
//           both clears on the same id, so the count stays exact.
// Ports   : ck, rst (sync, active-low)
//           set_en/set_id           - mark id outstanding
//           kill_clr_en/kill_clr_id - retire id due to commit kill
//           res_clr_en/res_clr_id   - retire id due to result
//           valid_bits              - one bit per id
//           count                   - number of bits set
// Revision: 1.0 - initial release
// ============================================================================
module rvfpm_xif_scoreboard
  import rvfpm_xif_pkg::*;
#(
  parameter int  X_ID_WIDTH      = 4,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int NUM_IDS         = 2 ** X_ID_WIDTH,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [X_ID_WIDTH-1:0] set_id,
  input  logic                  kill_clr_en,
  input  logic [X_ID_WIDTH-1:0] kill_clr_id,
  input  logic                  res_clr_en,
  input  logic [X_ID_WIDTH-1:0] res_clr_id,
  output logic [NUM_IDS-1:0]    valid_bits,
  output logic [CNT_W-1:0]      count
);

  logic [NUM_IDS-1:0] set_vec;
  logic [NUM_IDS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en)      set_vec[set_id]      = 1'b1;
    if (kill_clr_en) clr_vec[kill_clr_id] = 1'b1;
    if (res_clr_en)  clr_vec[res_clr_id]  = 1'b1;
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      valid_bits <= '0;
      count      <= '0;
    end else begin
      // Set and clear never target the same id in one cycle (issue stalls
      // while the next id is still outstanding), so ordering is irrelevant.
      valid_bits <= (valid_bits & ~clr_vec) | set_vec;
      count      <= count + CNT_W'(set_en) - CNT_W'(kill_clr_en) - CNT_W'(res_clr_en);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rvfpm_xif_initiator.sv
`default_nettype none
// ============================================================================
// Module  : rvfpm_xif_initiator
// Purpose : Core-side CORE-V-XIF initiator for the rvfpm coprocessor. Takes
//           offloaded instructions from decode, issues each with a unique id,
//           commits it (optionally as a kill), tracks ids that will write an
//           X register, and forwards matching results to the X register file.
// Ports   : ck, rst (sync, active-low)
//           instr_*          - core offer (valid/ready, word, rs1, kill)
//           issue_*          - XIF issue request and response
//           commit_*         - XIF commit pulse
//           result_*         - XIF result channel
//           toXReg_valid, data_toXReg - X register write
//           instr_rejected, err_unexp_id - single-cycle status pulses
//           outstanding      - ids awaiting a result
// Revision: 1.0 - initial release
// ============================================================================
module rvfpm_xif_initiator
  import rvfpm_xif_pkg::*;
#(
  parameter int  X_ID_WIDTH      = 4,
  parameter int  XLEN            = 32,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int NUM_IDS         = 2 ** X_ID_WIDTH,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       instr_rs1,
  input  logic                  instr_kill,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [31:0]           issue_instr,
  output logic [XLEN-1:0]       issue_rs1,
  output logic [X_ID_WIDTH-1:0] issue_id,
  input  logic                  issue_accept,
  input  logic                  issue_writeback,
  output logic                  commit_valid,
  output logic [X_ID_WIDTH-1:0] commit_id,
  output logic                  commit_kill,
  input  logic                  result_valid,
  output logic                  result_ready,
  input  logic [X_ID_WIDTH-1:0] result_id,
  input  logic [XLEN-1:0]       result_data,
  output logic                  toXReg_valid,
  output logic [XLEN-1:0]       data_toXReg,
  output logic                  instr_rejected,
  output logic                  err_unexp_id,
  output logic [CNT_W-1:0]      outstanding
);

  initiator_state_t        state;
  logic [X_ID_WIDTH-1:0]   next_id;
  logic                    running;

  logic [NUM_IDS-1:0]      sb_bits;
  logic [CNT_W-1:0]        sb_count;

  logic                    issue_hs;
  logic                    sb_set;
  logic                    kill_hit;
  logic                    result_hs;
  logic                    result_hit;

  // running rises one cycle after reset is released; it gates both ready
  // outputs so nothing is offered while reset is asserted.
  assign result_ready = running;

  assign instr_ready = running
                    && (state == IDLE)
                    && (sb_count < CNT_W'(MAX_OUTSTANDING))
                    && !sb_bits[next_id];

  assign issue_hs  = issue_valid && issue_ready;
  assign sb_set    = issue_hs && issue_accept && issue_writeback;

  // Kill is sampled live during the single COMMIT cycle.
  assign commit_kill = commit_valid && instr_kill;
  assign kill_hit    = commit_kill && sb_bits[commit_id];

  // A kill takes precedence over a same-cycle result for the same id; that
  // result is then reported as unexpected.
  assign result_hs  = result_valid && result_ready;
  assign result_hit = result_hs && sb_bits[result_id]
                   && !(kill_hit && (result_id == commit_id));

  assign outstanding = sb_count;

  rvfpm_xif_scoreboard #(
    .X_ID_WIDTH      (X_ID_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .ck          (ck),
    .rst         (rst),
    .set_en      (sb_set),
    .set_id      (issue_id),
    .kill_clr_en (kill_hit),
    .kill_clr_id (commit_id),
    .res_clr_en  (result_hit),
    .res_clr_id  (result_id),
    .valid_bits  (sb_bits),
    .count       (sb_count)
  );

  always_ff @(posedge ck) begin
    if (!rst) begin
      state          <= IDLE;
      next_id        <= '0;
      running        <= 1'b0;
      issue_valid    <= 1'b0;
      issue_instr    <= '0;
      issue_rs1      <= '0;
      issue_id       <= '0;
      commit_valid   <= 1'b0;
      commit_id      <= '0;
      instr_rejected <= 1'b0;
      toXReg_valid   <= 1'b0;
      data_toXReg    <= '0;
      err_unexp_id   <= 1'b0;
    end else begin
      running        <= 1'b1;
      commit_valid   <= 1'b0;
      instr_rejected <= 1'b0;
      toXReg_valid   <= 1'b0;
      err_unexp_id   <= 1'b0;

      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            issue_valid <= 1'b1;
            issue_instr <= instr;
            issue_rs1   <= instr_rs1;
            issue_id    <= next_id;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Payload registers stay untouched until the handshake.
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (issue_accept) begin
              next_id      <= next_id + 1'b1;
              commit_valid <= 1'b1;
              commit_id    <= issue_id;
              state        <= COMMIT;
            end else begin
              // Rejected ids are not consumed; the next offer reuses it.
              instr_rejected <= 1'b1;
              state          <= IDLE;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (result_hit) begin
        toXReg_valid <= 1'b1;
        data_toXReg  <= result_data;
      end else if (result_hs) begin
        err_unexp_id <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
